// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and write-back, and drives the datapath muxes and strobes.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       funct3_0,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t cur;
    // Cleared by reset so every output stays 0 until the first edge after release;
    // the first FETCH request therefore appears one cycle after rst_n rises.
    logic   active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= FETCH;
            active <= 1'b0;
        end else if (!active) begin
            active <= 1'b1;
        end else begin
            case (cur)
                FETCH:  if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: cur <= MEMADR;
                        OP_RTYPE:          cur <= EXEC_R;
                        OP_ITYPE:          cur <= EXEC_I;
                        OP_BRANCH:         cur <= BRANCH;
                        OP_JAL:            cur <= JAL;
                        default:           cur <= TRAP;
                    endcase
                end
                MEMADR: cur <= (opcode == OP_LOAD) ? MEMRD : MEMWR;
                MEMRD:  if (mem_ready) cur <= MEMWB;
                MEMWB:  cur <= FETCH;
                MEMWR:  if (mem_ready) cur <= FETCH;
                EXEC_R: cur <= ALUWB;
                EXEC_I: cur <= ALUWB;
                ALUWB:  cur <= FETCH;
                BRANCH: cur <= FETCH;
                JAL:    cur <= ALUWB;
                TRAP:   cur <= TRAP;
                default: cur <= TRAP;
            endcase
        end
    end

    assign state = cur;

    // Memory handshake: mem_req is high for the whole of FETCH, MEMRD and MEMWR,
    // with mem_we/adr_src stable, until an edge samples mem_ready=1; strobes
    // qualified by mem_ready fire only in that completing cycle, and mem_ready
    // is ignored in every other state.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (active) begin
            case (cur)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                end
                EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = zero ^ funct3_0;
                    retire    = 1'b1;
                end
                JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors
// are queued from a table of the state behaviour and compared at negedge.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       funct3_0;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [3:0] state;
    logic       retire;
    logic       illegal;

    localparam int W = 20;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3_0(funct3_0),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .state(state),
        .retire(retire), .illegal(illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] obs_vec();
        return {state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, retire, illegal};
    endfunction

    // Expected outputs for one cycle, written straight from the state table.
    function automatic logic [W-1:0] model_vec(int st, bit mr, bit z, bit f3);
        logic       rq, we, adr, irw, pcw, rw, ret, ill;
        logic [1:0] a, b, op, rs;
        {rq, we, adr, irw, pcw, rw, ret, ill} = '0;
        {a, b, op, rs} = '0;
        case (st)
            0:  begin rq = 1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin rq = 1; adr = 1; end
            4:  begin rs = 2'b01; rw = 1; ret = 1; end
            5:  begin rq = 1; we = 1; adr = 1; ret = mr; end
            6:  begin a = 2'b10; op = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; op = 2'b11; end
            8:  begin rw = 1; ret = 1; end
            9:  begin a = 2'b10; op = 2'b01; pcw = z ^ f3; ret = 1; end
            10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            11: ill = 1;
            default: ;
        endcase
        return {4'(st), rq, we, adr, irw, pcw, rw, a, b, op, rs, ret, ill};
    endfunction

    // driver: one cycle of inputs, then record outputs away from the edge
    task automatic drive_cycle(input bit mr, input bit z, input bit f3);
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        funct3_0  = f3;
        @(negedge clk);
        obs_q.push_back(obs_vec());
    endtask

    task automatic run_trace(input logic [6:0] op, input int st[$], input bit mr[$],
                             input bit z, input bit f3);
        opcode = op;
        for (int i = 0; i < st.size(); i++) begin
            exp_q.push_back(model_vec(st[i], mr[i], z, f3));
            drive_cycle(mr[i], z, f3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = '0; funct3_0 = 0; zero = 0; mem_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obs_vec(), {W{1'b0}});
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_release_same_cycle: got %h expected %h", obs_vec(), {W{1'b0}});
        end
    endtask

    task automatic scoreboard_compare(input string name);
        while (exp_q.size() > 0) begin
            logic [W-1:0] e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s: got no output expected %h", name, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", name, o, e);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_r_type();
        run_trace(7'b0110011, '{0, 1, 6, 8, 0}, '{1, 1, 1, 1, 0}, 0, 0);
        scoreboard_compare("r_type");
    endtask

    task automatic test_i_type();
        bit r1, r2;
        r1 = 1'($urandom_range(0, 1));
        r2 = 1'($urandom_range(0, 1));
        run_trace(7'b0010011, '{0, 1, 7, 8, 0}, '{1, r1, r2, 1, 0}, 0, 0);
        scoreboard_compare("i_type");
    endtask

    task automatic test_load_wait();
        bit r1, r2, r3;
        r1 = 1'($urandom_range(0, 1));
        r2 = 1'($urandom_range(0, 1));
        r3 = 1'($urandom_range(0, 1));
        run_trace(7'b0000011, '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0},
                  '{0, 0, 1, r1, r2, 0, 0, 1, r3, 0}, 0, 0);
        scoreboard_compare("load_wait");
    endtask

    task automatic test_store();
        run_trace(7'b0100011, '{0, 1, 2, 5, 5, 0}, '{1, 0, 1, 0, 1, 0}, 0, 0);
        scoreboard_compare("store");
    endtask

    task automatic test_branch();
        bit zs[4] = '{1, 0, 0, 1};
        bit fs[4] = '{0, 0, 1, 1};
        for (int k = 0; k < 4; k++) begin
            run_trace(7'b1100011, '{0, 1, 9, 0}, '{1, 1, 1, 0}, zs[k], fs[k]);
            scoreboard_compare($sformatf("branch_z%0d_f%0d", zs[k], fs[k]));
        end
    endtask

    task automatic test_jal();
        run_trace(7'b1101111, '{0, 1, 10, 8, 0}, '{1, 0, 1, 1, 0}, 0, 0);
        scoreboard_compare("jal");
    endtask

    task automatic test_back_to_back();
        run_trace(7'b0110011, '{0, 1, 6, 8}, '{1, 1, 1, 1}, 0, 0);
        run_trace(7'b0010011, '{0, 1, 7, 8}, '{1, 1, 1, 1}, 0, 0);
        run_trace(7'b1100011, '{0, 1, 9, 0}, '{1, 1, 1, 0}, 1, 0);
        scoreboard_compare("back_to_back");
    endtask

    task automatic test_reset_mid_store();
        run_trace(7'b0100011, '{0, 1, 2, 5}, '{1, 1, 1, 0}, 0, 0);
        scoreboard_compare("store_before_reset");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, state} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_drop: got req=%b we=%b state=%0d expected 0 0 0",
                     mem_req, mem_we, state);
        end
        drive_cycle(1, 0, 0);
        checks++;
        if (obs_q[0] !== '0) begin
            errors++;
            $display("FAIL reset_held_with_ready: got %h expected %h", obs_q[0], {W{1'b0}});
        end
        obs_q.delete();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_before_first_edge: got %b expected 0", mem_req);
        end
        run_trace(7'b0100011, '{0, 0}, '{0, 0}, 0, 0);
        scoreboard_compare("fetch_after_reset");
    endtask

    task automatic test_trap();
        int st[$];
        bit mr[$];
        st = '{0, 1};
        mr = '{1, 1};
        for (int i = 0; i < 20; i++) begin
            st.push_back(11);
            mr.push_back(1'(i % 2) ^ 1'($urandom_range(0, 1)));
        end
        run_trace(7'b1110011, st, mr, 0, 0);
        scoreboard_compare("trap");
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_load_wait();
        test_store();
        test_branch();
        test_jal();
        test_back_to_back();
        test_reset_mid_store();
        test_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
